// File: rtl/pe_tap_sequencer.sv
// pe_tap_sequencer
// Initiator side of the PE operand interface. Takes (weight, image) pairs
// from a ready/valid stream and plays them into one PE, one tap at a time.
// Each tap loads the weight (LOADW) and then fires the image (FIRE).
// The PE's psum_out is fed back as the next psum_in, so the partial sum
// accumulates across TAPS taps. The finished Q7.8 dot product is then
// offered on a ready/valid result stream.
// The sequencer does no arithmetic of its own. acc is simply the last
// psum_out the PE produced, so any rounding or saturation is the PE's.

module pe_tap_sequencer #(
   parameter int TAPS  = 3,
   parameter int CNT_W = 8
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             abort,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [15:0]      in_weight,
   input  logic [15:0]      in_image,
   output logic [15:0]      weight_val,
   output logic             weight_en,
   output logic [15:0]      image_val,
   output logic             image_en,
   output logic [15:0]      psum_in,
   input  logic [15:0]      psum_out,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [15:0]      out_data,
   output logic [CNT_W-1:0] tap_cnt
);

   typedef enum logic [1:0] {
      ACCEPT,
      LOADW,
      FIRE,
      OUT
   } state_t;

   // Pre-increment tap count seen in FIRE on the last tap of a result
   localparam logic [CNT_W-1:0] LAST_TAP = CNT_W'(TAPS - 1);

   state_t      state;
   logic [15:0] w_hold;
   logic [15:0] i_hold;
   logic [15:0] acc;

   // Sequencer FSM: operand capture, per-tap load/fire, result hand-off.
   // Abort outranks every transition and discards the partial sum.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state   <= ACCEPT;
         w_hold  <= '0;
         i_hold  <= '0;
         acc     <= '0;
         tap_cnt <= '0;
      end else if (abort) begin
         state   <= ACCEPT;
         acc     <= '0;
         tap_cnt <= '0;
      end else begin
         case (state)
            ACCEPT: begin
               if (in_valid) begin
                  w_hold <= in_weight;
                  i_hold <= in_image;
                  state  <= LOADW;
               end
            end
            LOADW: begin
               state <= FIRE;
            end
            FIRE: begin
               acc     <= psum_out;
               tap_cnt <= tap_cnt + CNT_W'(1);
               if (tap_cnt == LAST_TAP) begin
                  state <= OUT;
               end else begin
                  state <= ACCEPT;
               end
            end
            OUT: begin
               if (out_ready) begin
                  acc     <= '0;
                  tap_cnt <= '0;
                  state   <= ACCEPT;
               end
            end
            default: begin
               state <= ACCEPT;
            end
         endcase
      end
   end

   // Handshake and PE strobes decode straight from the state register.
   // in_ready is also gated by reset and by abort, so a pair offered while
   // either is active is never taken.
   assign in_ready   = rst_n && (state == ACCEPT) && !abort;
   assign weight_en  = (state == LOADW);
   assign weight_val = (state == LOADW) ? w_hold : 16'h0000;
   assign image_en   = (state == FIRE);
   assign image_val  = (state == FIRE) ? i_hold : 16'h0000;
   assign psum_in    = acc;
   assign out_valid  = (state == OUT);
   assign out_data   = (state == OUT) ? acc : 16'h0000;

endmodule

// File: tb/tb_pe_tap_sequencer.sv
// tb_pe_tap_sequencer
// Directed bench for pe_tap_sequencer. There are three instances,
// with TAPS=3, TAPS=1 and TAPS=2. Each one drives a behavioural PE.
// The PE computes psum_out = sat16(psum_in + sat16((w * image) >>> 8)).
// It uses the weight captured on weight_en.

module tb_pe_tap_sequencer;

   logic        clk;
   logic        rst_n;

   logic        abort_a     [3];
   logic        in_valid_a  [3];
   logic        in_ready_a  [3];
   logic [15:0] in_weight_a [3];
   logic [15:0] in_image_a  [3];
   logic [15:0] weight_val_a[3];
   logic        weight_en_a [3];
   logic [15:0] image_val_a [3];
   logic        image_en_a  [3];
   logic [15:0] psum_in_a   [3];
   logic [15:0] psum_out_a  [3];
   logic        out_valid_a [3];
   logic        out_ready_a [3];
   logic [15:0] out_data_a  [3];
   logic [7:0]  tap_cnt_a   [3];

   logic [15:0] pe_w [3];

   int n_checks;
   int n_errors;

   logic [15:0] stim_w [4];
   logic [15:0] stim_i [4];
   int          we_at  [8];
   int          ie_at  [8];
   logic [15:0] ps_at  [8];
   int          nwe;
   int          nie;
   int          ov_cyc;

   pe_tap_sequencer #(.TAPS(3), .CNT_W(8)) dut3 (
      .clk(clk), .rst_n(rst_n), .abort(abort_a[0]),
      .in_valid(in_valid_a[0]), .in_ready(in_ready_a[0]),
      .in_weight(in_weight_a[0]), .in_image(in_image_a[0]),
      .weight_val(weight_val_a[0]), .weight_en(weight_en_a[0]),
      .image_val(image_val_a[0]), .image_en(image_en_a[0]),
      .psum_in(psum_in_a[0]), .psum_out(psum_out_a[0]),
      .out_valid(out_valid_a[0]), .out_ready(out_ready_a[0]),
      .out_data(out_data_a[0]), .tap_cnt(tap_cnt_a[0])
   );

   pe_tap_sequencer #(.TAPS(1), .CNT_W(8)) dut1 (
      .clk(clk), .rst_n(rst_n), .abort(abort_a[1]),
      .in_valid(in_valid_a[1]), .in_ready(in_ready_a[1]),
      .in_weight(in_weight_a[1]), .in_image(in_image_a[1]),
      .weight_val(weight_val_a[1]), .weight_en(weight_en_a[1]),
      .image_val(image_val_a[1]), .image_en(image_en_a[1]),
      .psum_in(psum_in_a[1]), .psum_out(psum_out_a[1]),
      .out_valid(out_valid_a[1]), .out_ready(out_ready_a[1]),
      .out_data(out_data_a[1]), .tap_cnt(tap_cnt_a[1])
   );

   pe_tap_sequencer #(.TAPS(2), .CNT_W(8)) dut2 (
      .clk(clk), .rst_n(rst_n), .abort(abort_a[2]),
      .in_valid(in_valid_a[2]), .in_ready(in_ready_a[2]),
      .in_weight(in_weight_a[2]), .in_image(in_image_a[2]),
      .weight_val(weight_val_a[2]), .weight_en(weight_en_a[2]),
      .image_val(image_val_a[2]), .image_en(image_en_a[2]),
      .psum_in(psum_in_a[2]), .psum_out(psum_out_a[2]),
      .out_valid(out_valid_a[2]), .out_ready(out_ready_a[2]),
      .out_data(out_data_a[2]), .tap_cnt(tap_cnt_a[2])
   );

   function automatic logic [15:0] sat16(input logic signed [31:0] v);
      if (v > 32'sd32767) return 16'h7FFF;
      else if (v < -32'sd32768) return 16'h8000;
      else return v[15:0];
   endfunction

   function automatic logic [15:0] pe_calc(input logic [15:0] w, input logic [15:0] img,
                                           input logic [15:0] p);
      logic signed [31:0] ws;
      logic signed [31:0] is;
      logic signed [31:0] prod;
      logic [15:0]        ps;
      ws   = {{16{w[15]}}, w};
      is   = {{16{img[15]}}, img};
      prod = (ws * is) >>> 8;
      ps   = sat16(prod);
      return sat16({{16{ps[15]}}, ps} + {{16{p[15]}}, p});
   endfunction

   // Behavioural PE weight registers, one per sequencer instance
   always @(posedge clk) begin
      for (int k = 0; k < 3; k++) begin
         if (weight_en_a[k]) pe_w[k] <= weight_val_a[k];
      end
   end

   assign psum_out_a[0] = pe_calc(pe_w[0], image_val_a[0], psum_in_a[0]);
   assign psum_out_a[1] = pe_calc(pe_w[1], image_val_a[1], psum_in_a[1]);
   assign psum_out_a[2] = pe_calc(pe_w[2], image_val_a[2], psum_in_a[2]);

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_errors++;
         $display("[TB] FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   task automatic tick;
      @(posedge clk);
      #1;
   endtask

   // Streams npairs pairs from stim_w/stim_i into instance sel, with
   // out_ready low. It stops in the first cycle out_valid is seen.
   // Expected strobes: weight_en in the cycle after an accept, and image_en
   // in the cycle after that.
   task automatic applyStimulus(input int sel, input int npairs, input bit bubbles,
                                input logic [15:0] exp_res, input string tag);
      int p;
      int pat;
      bit hs;
      bit hs_d;
      bit we_d;
      p = 0; pat = 0; hs_d = 0; we_d = 0;
      nwe = 0; nie = 0; ov_cyc = 0;
      in_valid_a[sel] = 1'b0;
      for (int cyc = 1; cyc <= 80; cyc++) begin
         if (!in_valid_a[sel] && p < npairs && (!bubbles || (pat % 4) == 0)) begin
            in_valid_a[sel]  = 1'b1;
            in_weight_a[sel] = stim_w[p];
            in_image_a[sel]  = stim_i[p];
         end
         #1;
         checkOutput({tag, "_weight_en"}, weight_en_a[sel], hs_d);
         checkOutput({tag, "_image_en"}, image_en_a[sel], we_d);
         if (weight_en_a[sel] && nwe < 8) begin
            we_at[nwe] = cyc;
            nwe++;
         end
         if (image_en_a[sel] && nie < 8) begin
            ie_at[nie] = cyc;
            ps_at[nie] = psum_in_a[sel];
            nie++;
         end
         if (out_valid_a[sel]) begin
            ov_cyc = cyc;
            break;
         end
         hs   = in_valid_a[sel] && in_ready_a[sel];
         we_d = hs_d;
         hs_d = hs;
         tick();
         if (hs) begin
            in_valid_a[sel] = 1'b0;
            p++;
         end
         pat++;
      end
      in_valid_a[sel] = 1'b0;
      checkOutput({tag, "_out_valid_seen"}, ov_cyc != 0, 1);
      checkOutput({tag, "_out_data"}, out_data_a[sel], exp_res);
   endtask

   // Retires the pending result of instance sel with a one-cycle out_ready
   task automatic retire(input int sel);
      out_ready_a[sel] = 1'b1;
      tick();
      out_ready_a[sel] = 1'b0;
      #1;
   endtask

   initial begin
      int exp_we [3];
      int exp_ie [3];
      logic [15:0] exp_ps [3];
      bit found;
      exp_we = '{2, 5, 8};
      exp_ie = '{3, 6, 9};
      exp_ps = '{16'h0000, 16'h0200, 16'h0400};
      n_checks = 0;
      n_errors = 0;
      for (int k = 0; k < 3; k++) begin
         abort_a[k] = 1'b0; in_valid_a[k] = 1'b0; out_ready_a[k] = 1'b0;
         in_weight_a[k] = '0; in_image_a[k] = '0;
      end

      // Reset values
      rst_n = 1'b0;
      #3;
      checkOutput("rst_in_ready", in_ready_a[0], 0);
      checkOutput("rst_out_valid", out_valid_a[0], 0);
      checkOutput("rst_tap_cnt", tap_cnt_a[0], 0);
      checkOutput("rst_psum_in", psum_in_a[0], 0);
      #4;
      rst_n = 1'b1;
      tick();
      checkOutput("idle_in_ready", in_ready_a[0], 1);

      // Basic dot product with cycle-exact strobe placement
      stim_w[0] = 16'd256; stim_i[0] = 16'd512;
      stim_w[1] = 16'd512; stim_i[1] = 16'd256;
      stim_w[2] = 16'd128; stim_i[2] = 16'd1024;
      applyStimulus(0, 3, 1'b0, 16'd1536, "basic");
      for (int k = 0; k < 3; k++) begin
         checkOutput($sformatf("basic_we_cycle%0d", k), we_at[k], exp_we[k]);
         checkOutput($sformatf("basic_ie_cycle%0d", k), ie_at[k], exp_ie[k]);
         checkOutput($sformatf("basic_psum%0d", k), ps_at[k], exp_ps[k]);
      end
      checkOutput("basic_out_cycle", ov_cyc, 10);
      checkOutput("basic_tap_cnt", tap_cnt_a[0], 3);

      // Backpressure, with a pair offered throughout
      in_valid_a[0] = 1'b1; in_weight_a[0] = 16'd256; in_image_a[0] = 16'd256;
      for (int k = 0; k < 5; k++) begin
         tick();
         checkOutput("bp_out_valid", out_valid_a[0], 1);
         checkOutput("bp_out_data", out_data_a[0], 16'd1536);
         checkOutput("bp_in_ready", in_ready_a[0], 0);
         checkOutput("bp_strobes", {weight_en_a[0], image_en_a[0]}, 0);
      end
      retire(0);
      checkOutput("ret_in_ready", in_ready_a[0], 1);
      checkOutput("ret_tap_cnt", tap_cnt_a[0], 0);
      checkOutput("ret_psum_in", psum_in_a[0], 0);
      checkOutput("ret_out_valid", out_valid_a[0], 0);
      checkOutput("ret_no_accept", weight_en_a[0], 0);
      in_valid_a[0] = 1'b0;
      tick();

      // Input bubbles give the same result
      applyStimulus(0, 3, 1'b1, 16'd1536, "bubble");
      retire(0);

      // Abort during FIRE of the second tap
      in_valid_a[0] = 1'b1; in_weight_a[0] = 16'd256; in_image_a[0] = 16'd512;
      found = 1'b0;
      for (int k = 0; k < 20; k++) begin
         if (image_en_a[0] && tap_cnt_a[0] == 8'd1) begin
            found = 1'b1;
            break;
         end
         tick();
      end
      checkOutput("abort_reach_fire", found, 1);
      in_valid_a[0] = 1'b0;
      abort_a[0] = 1'b1;
      tick();
      abort_a[0] = 1'b0;
      #1;
      checkOutput("abort_in_ready", in_ready_a[0], 1);
      checkOutput("abort_tap_cnt", tap_cnt_a[0], 0);
      checkOutput("abort_psum_in", psum_in_a[0], 0);
      checkOutput("abort_strobes", {weight_en_a[0], image_en_a[0]}, 0);

      // A pair offered together with abort is not taken
      abort_a[0] = 1'b1; in_valid_a[0] = 1'b1;
      #1;
      checkOutput("abort_cycle_in_ready", in_ready_a[0], 0);
      tick();
      abort_a[0] = 1'b0; in_valid_a[0] = 1'b0;
      checkOutput("abort_cycle_no_load", weight_en_a[0], 0);

      // Fresh stream after abort
      for (int k = 0; k < 3; k++) begin
         stim_w[k] = 16'd256; stim_i[k] = 16'd256;
      end
      applyStimulus(0, 3, 1'b0, 16'd768, "post_abort");

      // Reset asserted while a result is pending
      #1;
      rst_n = 1'b0;
      #1;
      checkOutput("rstout_out_valid", out_valid_a[0], 0);
      checkOutput("rstout_out_data", out_data_a[0], 0);
      checkOutput("rstout_in_ready", in_ready_a[0], 0);
      checkOutput("rstout_tap_cnt", tap_cnt_a[0], 0);
      checkOutput("rstout_psum_in", psum_in_a[0], 0);
      tick();
      checkOutput("rstout_hold_in_ready", in_ready_a[0], 0);
      rst_n = 1'b1;
      tick();
      checkOutput("rstout_release_in_ready", in_ready_a[0], 1);

      // TAPS=1, negative product
      stim_w[0] = 16'hFF00; stim_i[0] = 16'h0100;
      applyStimulus(1, 1, 1'b0, 16'hFF00, "taps1");
      checkOutput("taps1_out_cycle", ov_cyc, 4);
      retire(1);

      // TAPS=2, saturating first product, then a negative tap
      stim_w[0] = 16'h4000; stim_i[0] = 16'h0200;
      stim_w[1] = 16'hFF00; stim_i[1] = 16'h0100;
      applyStimulus(2, 2, 1'b0, 16'h7EFF, "taps2");
      retire(2);

      $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
      $finish;
   end

endmodule
